// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared micro-op types, FU encodings, ALU op codes and FIFO occupancy states.
// Exports: uop_t, FU_* codes, ALU_* codes, occ_t (EMPTY/ONE/FULL).
package dispatch_pkg;

    typedef struct packed {
        logic [8:0]  pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic [1:0]  fu_type;
        logic        alusrc;
        logic        branch;
        logic        memread;
        logic        memwrite;
        logic        regwrite;
    } uop_t;

    localparam logic [1:0] FU_ALU = 2'b00;
    localparam logic [1:0] FU_BR  = 2'b01;
    localparam logic [1:0] FU_LSU = 2'b10;
    localparam logic [1:0] FU_ILL = 2'b11;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SRL = 4'd7;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

endpackage

// File: rtl/dispatch_if.sv
// dispatch_if: decoder-side, station-side, ROB and flush signals of the dispatch stage.
// Modports: slave = dispatch_ctrl, master = environment driving decoder/stations/ROB.
interface dispatch_if;
    import dispatch_pkg::*;

    logic       i_valid;
    uop_t       i_uop;
    logic       o_ready;
    uop_t       o_uop;
    logic       alu_valid;
    logic       br_valid;
    logic       lsu_valid;
    logic       alu_ready;
    logic       br_ready;
    logic       lsu_ready;
    logic       rob_ready;
    logic       rob_alloc;
    logic       flush;
    logic       o_illegal;
    logic [1:0] o_count;

    modport slave (
        input  i_valid, i_uop, alu_ready, br_ready, lsu_ready, rob_ready, flush,
        output o_ready, o_uop, alu_valid, br_valid, lsu_valid, rob_alloc, o_illegal, o_count
    );

    modport master (
        output i_valid, i_uop, alu_ready, br_ready, lsu_ready, rob_ready, flush,
        input  o_ready, o_uop, alu_valid, br_valid, lsu_valid, rob_alloc, o_illegal, o_count
    );

endinterface

// File: rtl/uop_fifo2.sv
// uop_fifo2: 2-entry in-order micro-op FIFO; occupancy kept as an EMPTY/ONE/FULL state.
// Ports: clk, rst_n (async low), push/pop/clear controls, din in, dout = head, count = occupancy.
// Callers never push when full nor pop when empty; clear overrides push and pop.
module uop_fifo2
    import dispatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       clear,
    input  uop_t       din,
    output uop_t       dout,
    output logic [1:0] count
);

    uop_t mem [2];
    logic wr_ptr;
    logic rd_ptr;
    occ_t st;
    occ_t nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            st     <= nxt;
            wr_ptr <= clear ? 1'b0 : wr_ptr ^ push;
            rd_ptr <= clear ? 1'b0 : rd_ptr ^ pop;
            if (push && !clear)
                mem[wr_ptr] <= din;
        end
    end

    always_comb begin
        nxt = st;
        if (clear)
            nxt = EMPTY;
        else if (push && !pop)
            nxt = (st == EMPTY) ? ONE : FULL;
        else if (pop && !push)
            nxt = (st == FULL) ? ONE : EMPTY;
    end

    assign dout  = mem[rd_ptr];
    assign count = st;

endmodule

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: routes the FIFO head to the ALU/branch/LSU station selected by fu_type, gated by ROB space.
// Ports: clk, rst_n (async low), bus (dispatch_if.slave): decoder handshake, station valid/ready,
// rob_ready/rob_alloc, flush, sticky o_illegal, o_count occupancy.
module dispatch_ctrl
    import dispatch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    dispatch_if.slave  bus
);

    uop_t       head;
    logic [1:0] count;
    logic       ready;
    logic       live;
    logic       fire;
    logic       ill;
    logic       push;
    logic       pop;
    logic       illegal;

    uop_fifo2 u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (bus.flush),
        .din   (bus.i_uop),
        .dout  (head),
        .count (count)
    );

    // o_ready looks only at occupancy and flush, so downstream readiness never reaches upstream combinationally.
    assign ready = (count != 2'(DEPTH)) && !bus.flush;
    assign live  = (count != 2'd0) && !bus.flush;
    assign push  = bus.i_valid && ready;

    assign bus.alu_valid = live && bus.rob_ready && (head.fu_type == FU_ALU);
    assign bus.br_valid  = live && bus.rob_ready && (head.fu_type == FU_BR);
    assign bus.lsu_valid = live && bus.rob_ready && (head.fu_type == FU_LSU);

    assign fire = (bus.alu_valid && bus.alu_ready) || (bus.br_valid && bus.br_ready) ||
                  (bus.lsu_valid && bus.lsu_ready);

    // Illegal heads are dropped without waiting for the ROB so they cannot block the queue.
    assign ill = live && (head.fu_type == FU_ILL);
    assign pop = fire || ill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal <= 1'b0;
        else if (ill)
            illegal <= 1'b1;
    end

    assign bus.o_ready   = ready;
    assign bus.o_uop     = head;
    assign bus.rob_alloc = fire;
    assign bus.o_illegal = illegal;
    assign bus.o_count   = count;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb_dispatch_ctrl: directed stimulus with a scoreboard of expected dispatches checked by a negedge monitor.
module tb_dispatch_ctrl;
    import dispatch_pkg::*;

    typedef struct packed {
        logic [1:0] fu;
        logic [8:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dispatch_if bus ();

    dispatch_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic uop_t mk(input logic [8:0] pc, input logic [1:0] fu);
        uop_t u;
        u = '0;
        u.pc       = pc;
        u.fu_type  = fu;
        u.rd       = 5'(pc[6:2]);
        u.rs1      = 5'd1;
        u.rs2      = 5'd2;
        u.imm      = 32'(pc) + 32'd100;
        u.alu_op   = ALU_ADD;
        u.branch   = (fu == FU_BR);
        u.memread  = (fu == FU_LSU);
        u.regwrite = (fu != FU_BR);
        return u;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic send(input logic [8:0] pc, input logic [1:0] fu, input bit expect_dispatch);
        bus.i_valid = 1'b1;
        bus.i_uop   = mk(pc, fu);
        if (expect_dispatch)
            sb.push_back('{fu: fu, pc: pc});
    endtask

    task automatic idle();
        bus.i_valid = 1'b0;
        bus.i_uop   = '0;
    endtask

    always @(negedge clk) begin : mon
        logic [2:0] f;
        exp_t       e;
        if (rst_n) begin
            f = {bus.lsu_valid && bus.lsu_ready, bus.br_valid && bus.br_ready, bus.alu_valid && bus.alu_ready};
            chk("rob_alloc_vs_fire", 32'(bus.rob_alloc), 32'(|f));
            chk("valid_onehot", 32'($countones({bus.alu_valid, bus.br_valid, bus.lsu_valid}) <= 1), 32'd1);
            if (|f) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_unexpected: dispatch pc %0h with no op expected", bus.o_uop.pc);
                end else begin
                    e = sb.pop_front();
                    chk("sb_unit", 32'(f == 3'b001 ? 2'd0 : f == 3'b010 ? 2'd1 : 2'd2), 32'(e.fu));
                    chk("sb_pc", 32'(bus.o_uop.pc), 32'(e.pc));
                end
            end
        end
    end

    initial begin
        bus.alu_ready = 1'b1;
        bus.br_ready  = 1'b1;
        bus.lsu_ready = 1'b1;
        bus.rob_ready = 1'b1;
        bus.flush     = 1'b0;
        idle();

        // reset state
        neg();
        chk("rst_count", 32'(bus.o_count), 32'd0);
        chk("rst_ready", 32'(bus.o_ready), 32'd1);
        chk("rst_valids", 32'({bus.alu_valid, bus.br_valid, bus.lsu_valid}), 32'd0);
        chk("rst_rob_alloc", 32'(bus.rob_alloc), 32'd0);
        chk("rst_illegal", 32'(bus.o_illegal), 32'd0);
        #2 rst_n = 1'b1;

        // single ADD: presented the cycle after the push, gone the cycle after
        cyc();
        send(9'h004, FU_ALU, 1'b1);
        cyc();
        idle();
        neg();
        chk("add_alu_valid", 32'(bus.alu_valid), 32'd1);
        chk("add_rob_alloc", 32'(bus.rob_alloc), 32'd1);
        chk("add_pc", 32'(bus.o_uop.pc), 32'h004);
        cyc();
        neg();
        chk("add_drained", 32'(bus.o_count), 32'd0);

        // BEQ + LW with branch station stalled
        bus.br_ready = 1'b0;
        send(9'h008, FU_BR, 1'b1);
        cyc();
        send(9'h00C, FU_LSU, 1'b1);
        cyc();
        idle();
        neg();
        chk("stall_count", 32'(bus.o_count), 32'd2);
        chk("stall_ready", 32'(bus.o_ready), 32'd0);
        chk("stall_br_valid", 32'(bus.br_valid), 32'd1);
        chk("stall_pc", 32'(bus.o_uop.pc), 32'h008);
        cyc();
        neg();
        chk("stall_hold_br_valid", 32'(bus.br_valid), 32'd1);
        chk("stall_hold_pc", 32'(bus.o_uop.pc), 32'h008);
        cyc();
        bus.br_ready = 1'b1;
        cyc();
        neg();
        chk("lw_lsu_valid", 32'(bus.lsu_valid), 32'd1);
        chk("lw_pc", 32'(bus.o_uop.pc), 32'h00C);
        chk("lw_count", 32'(bus.o_count), 32'd1);
        cyc();
        neg();
        chk("lw_drained", 32'(bus.o_count), 32'd0);

        // ROB full for 5 cycles with a full FIFO
        bus.rob_ready = 1'b0;
        cyc();
        send(9'h010, FU_ALU, 1'b1);
        cyc();
        send(9'h014, FU_ALU, 1'b1);
        cyc();
        idle();
        for (int i = 0; i < 5; i++) begin
            neg();
            chk("rob_stall_count", 32'(bus.o_count), 32'd2);
            chk("rob_stall_valid", 32'(bus.alu_valid), 32'd0);
            chk("rob_stall_alloc", 32'(bus.rob_alloc), 32'd0);
            cyc();
        end
        bus.rob_ready = 1'b1;
        neg();
        chk("rob_rel_first", 32'(bus.o_uop.pc), 32'h010);
        chk("rob_rel_first_valid", 32'(bus.alu_valid), 32'd1);
        cyc();
        neg();
        chk("rob_rel_second", 32'(bus.o_uop.pc), 32'h014);
        chk("rob_rel_second_valid", 32'(bus.alu_valid), 32'd1);
        cyc();
        neg();
        chk("rob_rel_drained", 32'(bus.o_count), 32'd0);

        // illegal fu_type, dropped even with the ROB full
        cyc();
        bus.rob_ready = 1'b0;
        send(9'h020, FU_ILL, 1'b0);
        cyc();
        idle();
        neg();
        chk("ill_count", 32'(bus.o_count), 32'd1);
        chk("ill_no_valid", 32'({bus.alu_valid, bus.br_valid, bus.lsu_valid}), 32'd0);
        chk("ill_no_alloc", 32'(bus.rob_alloc), 32'd0);
        chk("ill_not_yet", 32'(bus.o_illegal), 32'd0);
        cyc();
        bus.rob_ready = 1'b1;
        neg();
        chk("ill_popped", 32'(bus.o_count), 32'd0);
        chk("ill_flag", 32'(bus.o_illegal), 32'd1);
        repeat (10) cyc();
        neg();
        chk("ill_sticky", 32'(bus.o_illegal), 32'd1);

        // flush colliding with a push into count 1
        cyc();
        bus.alu_ready = 1'b0;
        send(9'h030, FU_ALU, 1'b0);
        cyc();
        send(9'h034, FU_ALU, 1'b0);
        bus.flush = 1'b1;
        neg();
        chk("flush_ready", 32'(bus.o_ready), 32'd0);
        chk("flush_valid", 32'(bus.alu_valid), 32'd0);
        chk("flush_alloc", 32'(bus.rob_alloc), 32'd0);
        cyc();
        bus.flush = 1'b0;
        bus.alu_ready = 1'b1;
        idle();
        neg();
        chk("flush_count", 32'(bus.o_count), 32'd0);
        chk("flush_no_valid", 32'(bus.alu_valid), 32'd0);
        cyc();
        neg();
        chk("flush_still_empty", 32'(bus.o_count), 32'd0);

        // reset dropped with a full FIFO
        cyc();
        bus.alu_ready = 1'b0;
        send(9'h040, FU_ALU, 1'b1);
        cyc();
        send(9'h044, FU_ALU, 1'b1);
        cyc();
        idle();
        neg();
        chk("prerst_count", 32'(bus.o_count), 32'd2);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_count", 32'(bus.o_count), 32'd0);
        chk("midrst_ready", 32'(bus.o_ready), 32'd1);
        chk("midrst_valids", 32'({bus.alu_valid, bus.br_valid, bus.lsu_valid}), 32'd0);
        chk("midrst_alloc", 32'(bus.rob_alloc), 32'd0);
        chk("midrst_illegal", 32'(bus.o_illegal), 32'd0);
        bus.alu_ready = 1'b1;
        cyc();
        cyc();
        neg();
        chk("inrst_valid", 32'(bus.alu_valid), 32'd0);
        #2 rst_n = 1'b1;

        // sustained throughput, one op per cycle
        cyc();
        send(9'h050, FU_ALU, 1'b1);
        cyc();
        send(9'h054, FU_LSU, 1'b1);
        cyc();
        send(9'h058, FU_BR, 1'b1);
        neg();
        chk("tput_ready", 32'(bus.o_ready), 32'd1);
        chk("tput_count", 32'(bus.o_count), 32'd1);
        cyc();
        idle();
        neg();
        chk("tput_last_pc", 32'(bus.o_uop.pc), 32'h058);
        chk("tput_last_valid", 32'(bus.br_valid), 32'd1);
        cyc();
        neg();
        chk("tput_drained", 32'(bus.o_count), 32'd0);

        cyc();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dispatch_ctrl.md
# dispatch_ctrl

Schedules decoded micro-ops from the decoder onto the three functional-unit reservation stations (ALU, branch, LSU). It sits between the decoder and the issue stage. Incoming micro-ops are held in a 2-entry in-order skid FIFO. The head is dispatched to the unit selected by its FU type, gated by that unit's ready and a free ROB slot. A pipeline flush empties the FIFO.

## Interface
Parameters:
- DEPTH, 2, FIFO entries; only 2 is supported. Pointers are 1 bit and the count is 2 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  decoder has a micro-op
- i_uop  in  uop_t  decoded micro-op: pc[8:0], rs1/rs2/rd[4:0], imm[31:0], alu_op[3:0], fu_type[1:0], alusrc, branch, memread, memwrite, regwrite
- o_ready  out  1  FIFO can accept; equals count != DEPTH and not flush
- o_uop  out  uop_t  FIFO head, shared by all units
- alu_valid / br_valid / lsu_valid  out  1 each  dispatch strobe to the ALU (fu_type 00), branch (01) and LSU (10) stations
- alu_ready / br_ready / lsu_ready  in  1 each  station can accept this cycle
- rob_ready  in  1  ROB has a free entry
- rob_alloc  out  1  ROB allocation pulse; high in any cycle a dispatch fires
- flush  in  1  mispredict or recovery pulse
- o_illegal  out  1  sticky flag; set when fu_type 11 is dropped, cleared only by reset
- o_count  out  2  current occupancy, 0..2

## Operation
- Push: fires when i_valid && o_ready; the entry is written at wr_ptr and wr_ptr toggles.
- Head decode: tgt = head.fu_type. The valid for tgt is asserted when count != 0 && rob_ready && !flush.
  - Outputs are one-hot; at most one of alu/br/lsu_valid is ever high.
- Dispatch: fires when the selected valid && its ready. Then rob_alloc = 1, rd_ptr toggles and the count decrements.
- Illegal head (fu_type 11):
  - No unit valid and no rob_alloc.
  - The entry is popped in that cycle unconditionally, regardless of rob_ready; o_illegal is set.
- Push and pop in the same cycle: the count is unchanged.
  - When count == 2, o_ready is 0, so a pop frees space only in the next cycle. There is no combinational path from downstream ready to upstream ready.
- Flush:
  - In the flush cycle all valids, rob_alloc and o_ready are forced to 0.
  - At the edge: count, rd_ptr and wr_ptr are set to 0. Any push or pop requested in that cycle is discarded; flush wins.
- Stalls: a head whose target station is not ready, or with rob_ready = 0, stays in place. o_uop stays stable while its valid is high; the valid stays asserted until taken or flushed.
- Effective state machine is the occupancy: EMPTY(0), ONE(1), FULL(2).
  - EMPTY→ONE: push
  - ONE→EMPTY: pop without push
  - ONE→FULL: push without pop
  - FULL→ONE: pop
  - any→EMPTY: flush

## Timing
- Reset (asynchronous, rst_n low):
  - count = 0, pointers = 0, o_illegal = 0
  - all unit valids = 0, rob_alloc = 0
  - o_ready = 1 once flush is low
  - o_uop = head storage; storage contents are don't-care, reset to 0
- Latency: a micro-op pushed at edge N is presented at the outputs during cycle N+1 when it reaches an empty FIFO.
- Throughput: 1 micro-op/cycle sustained with all units and the ROB ready.
- Valids, rob_alloc and o_uop are combinational from registered state plus ready inputs. o_ready is combinational from the count and flush only.
- Reset asserted mid-operation: queued entries are lost; no dispatch occurs after rst_n falls.

## Structure
- Shared package dispatch_pkg:
  - uop_t packed struct
  - FU_ALU = 2'b00, FU_BR = 2'b01, FU_LSU = 2'b10, FU_ILL = 2'b11
  - ALU op localparams shared with the decoder
- A single sub-module, uop_fifo2: 2-entry storage, pointers and count, with push/pop/clear ports. Routing and ROB gating stay in dispatch_ctrl.

## Test plan
- Reset then push ADD (fu 00, pc 0x004) with all ready → cycle+1: alu_valid = 1, rob_alloc = 1, o_uop.pc = 0x004; cycle+2: count = 0.
- Push a BEQ (pc 0x008) then an LW (pc 0x00C) back-to-back with br_ready = 0 → count = 2, o_ready = 0, br_valid held with pc 0x008. Raise br_ready → BEQ dispatched; LSU gets pc 0x00C the next cycle.
- rob_ready = 0 with a full FIFO for 5 cycles → no valid and no rob_alloc, count stays 2. Release → two dispatches in two consecutive cycles.
- fu_type 11 pushed → popped in 1 cycle, no valid, o_illegal = 1 and still 1 after 10 more cycles.
- flush in the same cycle as a push into count = 1 → next cycle count = 0, no valid; the pushed op is never dispatched.
- rst_n dropped mid-stream with count = 2 → all outputs at reset values immediately; o_count = 0.
